// File: rtl/inst_fetch_queued_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queued_pkg
// Description : Shared fetch-stage types: instruction-buffer entry and FSM.
// Revision    : 1.0 - initial queued-fetch release
// ============================================================================
package inst_fetch_queued_pkg;

    localparam int INST_WIDTH  = 32;
    localparam int FETCH_WIDTH = 4;
    localparam int QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [INST_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] npc;
    } ib_entry_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_queued_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_group_queue
// Description : Circular FIFO of fetch groups with slot masks and flush.
// Revision    : 1.0 - initial queued-fetch release
// ============================================================================
module fetch_group_queue #(
    parameter int FETCH_WIDTH = inst_fetch_queued_pkg::FETCH_WIDTH,
    parameter int QUEUE_DEPTH = inst_fetch_queued_pkg::QUEUE_DEPTH
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              flush,
    input  logic                                              enq,
    input  inst_fetch_queued_pkg::ib_entry_t [FETCH_WIDTH-1:0] enq_group,
    input  logic [FETCH_WIDTH-1:0]                            enq_mask,
    input  logic                                              deq,
    output inst_fetch_queued_pkg::ib_entry_t [FETCH_WIDTH-1:0] head_group,
    output logic [FETCH_WIDTH-1:0]                            head_mask,
    output logic                                              full,
    output logic [$clog2(QUEUE_DEPTH):0]                      count
);
    import inst_fetch_queued_pkg::*;

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    ib_entry_t [FETCH_WIDTH-1:0] r_group [QUEUE_DEPTH];
    logic [FETCH_WIDTH-1:0]      r_mask  [QUEUE_DEPTH];
    logic [PTR_W-1:0]            r_head;
    logic [PTR_W-1:0]            r_tail;
    logic [PTR_W:0]              r_count;
    logic                        w_enq;
    logic                        w_deq;
    logic                        w_empty;

    assign w_empty = (r_count == '0);
    assign full    = (r_count == (PTR_W+1)'(QUEUE_DEPTH));
    assign w_deq   = deq && !w_empty;
    // A full queue may still accept when the head leaves in the same cycle.
    assign w_enq   = enq && (!full || w_deq);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_W'(1);
            if (w_deq) r_head <= r_head + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_group[r_tail] <= enq_group;
            r_mask[r_tail]  <= enq_mask;
        end
    end

    assign head_group = r_group[r_head];
    assign head_mask  = w_empty ? '0 : r_mask[r_head];
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queued.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queued
// Description : Fetch stage issuing aligned group requests into a fetch queue.
// Revision    : 1.0 - initial queued-fetch release
// ============================================================================
module inst_fetch_queued #(
    parameter int FETCH_WIDTH = inst_fetch_queued_pkg::FETCH_WIDTH,
    parameter int INST_WIDTH  = inst_fetch_queued_pkg::INST_WIDTH,
    parameter int QUEUE_DEPTH = inst_fetch_queued_pkg::QUEUE_DEPTH,
    parameter logic [INST_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              stall,
    input  logic                                              redirect,
    input  logic [INST_WIDTH-1:0]                             redirect_pc,
    output logic [INST_WIDTH-1:0]                             bp_pc,
    input  logic                                              pred_taken,
    input  logic [INST_WIDTH-1:0]                             pc_predicted,
    output logic                                              proc2Icache_req,
    output logic [INST_WIDTH-1:0]                             proc2Icache_addr,
    input  logic                                              Icache2proc_ready,
    input  logic                                              Icache2proc_data_valid,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0]                 Icache2proc_data,
    output logic                                              insts_out_valid,
    input  logic                                              insts_out_ready,
    output inst_fetch_queued_pkg::ib_entry_t [FETCH_WIDTH-1:0] insts_out,
    output logic [FETCH_WIDTH-1:0]                            insts_out_mask
);
    import inst_fetch_queued_pkg::*;

    localparam int GROUP_BYTES = FETCH_WIDTH * 4;
    localparam int OFF         = $clog2(GROUP_BYTES);
    localparam int SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [INST_WIDTH-1:0] ALIGN_MASK = ~(INST_WIDTH'(GROUP_BYTES - 1));

    fetch_state_t                r_state;
    logic [INST_WIDTH-1:0]       r_fetch_pc;
    logic [INST_WIDTH-1:0]       r_inf_pc;
    logic [INST_WIDTH-1:0]       r_inf_npc;
    logic [SLOT_W-1:0]           r_inf_slot;

    logic [INST_WIDTH-1:0]       w_aligned;
    logic [INST_WIDTH-1:0]       w_next_pc;
    logic [SLOT_W-1:0]           w_slot;
    logic                        w_req;
    logic                        w_accept;
    logic                        w_enq;
    logic                        w_deq;
    logic                        w_full;
    logic [CNT_W-1:0]            w_count;
    ib_entry_t [FETCH_WIDTH-1:0] w_enq_group;
    logic [FETCH_WIDTH-1:0]      w_enq_mask;

    assign w_aligned = r_fetch_pc & ALIGN_MASK;
    assign w_next_pc = pred_taken ? pc_predicted : w_aligned + INST_WIDTH'(GROUP_BYTES);

    generate
        if (FETCH_WIDTH > 1) begin : g_slot_wide
            assign w_slot = r_fetch_pc[OFF-1:2];
        end else begin : g_slot_single
            assign w_slot = 1'b0;
        end
    endgenerate

    assign w_req    = !reset && (r_state == ST_FETCH) && !stall && !redirect && !w_full;
    assign w_accept = w_req && Icache2proc_ready;
    // Only a response to a live WAIT request is kept; KILL drops the stale one.
    assign w_enq    = (r_state == ST_WAIT) && Icache2proc_data_valid && !redirect;
    assign w_deq    = insts_out_valid && insts_out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
        end else begin
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= w_next_pc;
            end
            case (r_state)
                ST_FETCH: if (w_accept) r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (Icache2proc_data_valid) r_state <= ST_FETCH;
                    else if (redirect)          r_state <= ST_KILL;
                end
                ST_KILL:  if (Icache2proc_data_valid) r_state <= ST_FETCH;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_inf_pc   <= w_aligned;
            r_inf_npc  <= w_next_pc;
            r_inf_slot <= w_slot;
        end
    end

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_enq_group[i].inst = Icache2proc_data[i*INST_WIDTH +: INST_WIDTH];
            w_enq_group[i].pc   = r_inf_pc + INST_WIDTH'(4 * i);
            w_enq_group[i].npc  = (i == FETCH_WIDTH - 1) ? r_inf_npc
                                                         : r_inf_pc + INST_WIDTH'(4 * (i + 1));
            w_enq_mask[i]       = (i >= int'(r_inf_slot));
        end
    end

    fetch_group_queue #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .enq        (w_enq),
        .enq_group  (w_enq_group),
        .enq_mask   (w_enq_mask),
        .deq        (w_deq),
        .head_group (insts_out),
        .head_mask  (insts_out_mask),
        .full       (w_full),
        .count      (w_count)
    );

    assign bp_pc            = r_fetch_pc;
    assign proc2Icache_req  = w_req;
    assign proc2Icache_addr = w_aligned;
    assign insts_out_valid  = !reset && (w_count != '0) && !stall;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queued.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queued
// Description : Directed vector table plus multi-cycle sequences for the fetch stage.
// Revision    : 1.0 - initial queued-fetch release
// ============================================================================
module tb_inst_fetch_queued;
    import inst_fetch_queued_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] bp_pc;
    logic        pred_taken;
    logic [31:0] pc_predicted;
    logic        proc2Icache_req;
    logic [31:0] proc2Icache_addr;
    logic        Icache2proc_ready;
    logic        Icache2proc_data_valid;
    logic [127:0] Icache2proc_data;
    logic        insts_out_valid;
    logic        insts_out_ready;
    ib_entry_t [3:0] insts_out;
    logic [3:0]  insts_out_mask;

    inst_fetch_queued #(
        .FETCH_WIDTH (4),
        .INST_WIDTH  (32),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .stall                  (stall),
        .redirect               (redirect),
        .redirect_pc            (redirect_pc),
        .bp_pc                  (bp_pc),
        .pred_taken             (pred_taken),
        .pc_predicted           (pc_predicted),
        .proc2Icache_req        (proc2Icache_req),
        .proc2Icache_addr       (proc2Icache_addr),
        .Icache2proc_ready      (Icache2proc_ready),
        .Icache2proc_data_valid (Icache2proc_data_valid),
        .Icache2proc_data       (Icache2proc_data),
        .insts_out_valid        (insts_out_valid),
        .insts_out_ready        (insts_out_ready),
        .insts_out              (insts_out),
        .insts_out_mask         (insts_out_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        pred_taken;
        logic [31:0] pc_predicted;
        logic        ready;
        logic        dv;
        logic        out_ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [3:0]  e_mask;
        logic [31:0] e_pc0;
        logic [31:0] e_pc2;
        logic [31:0] e_npc3;
    } vec_t;

    vec_t vecs [12];

    int          n_chk;
    int          n_fail;
    logic [31:0] acc_addr;
    bit          pend;
    int          pend_cnt;
    int          lat;
    bit          auto_ic;
    int          n_acc;

    function automatic vec_t v(logic st, logic rd, logic [31:0] rpc, logic pt, logic [31:0] ppc,
                               logic rdy, logic dv, logic ordy, logic er, logic [31:0] ea,
                               logic ev, logic [3:0] em, logic [31:0] p0, logic [31:0] p2,
                               logic [31:0] n3);
        vec_t r;
        r.stall = st; r.redirect = rd; r.redirect_pc = rpc; r.pred_taken = pt;
        r.pc_predicted = ppc; r.ready = rdy; r.dv = dv; r.out_ready = ordy;
        r.e_req = er; r.e_addr = ea; r.e_valid = ev; r.e_mask = em;
        r.e_pc0 = p0; r.e_pc2 = p2; r.e_npc3 = n3;
        return r;
    endfunction

    function automatic logic [31:0] inst_word(logic [31:0] a, int i);
        return a ^ (32'hC0DE_0000 | 32'(i));
    endfunction

    function automatic logic [127:0] group_data(logic [31:0] a);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = inst_word(a, i);
        return d;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural I-cache: answers lat cycles after each accepted request.
    task automatic ic_drive();
        Icache2proc_data_valid = 1'b0;
        if (auto_ic && pend) begin
            if (pend_cnt == 0) begin
                Icache2proc_data_valid = 1'b1;
                Icache2proc_data       = group_data(acc_addr);
                pend                   = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic ic_sample();
        if (proc2Icache_req && Icache2proc_ready) begin
            acc_addr = proc2Icache_addr;
            pend     = 1'b1;
            pend_cnt = lat - 1;
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; pred_taken = 1'b0;
        pc_predicted = '0; Icache2proc_ready = 1'b0; Icache2proc_data_valid = 1'b0;
        insts_out_ready = 1'b0;
    endtask

    task automatic do_reset(string tag);
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        #1;
        chk({tag, " reset req"},   32'(proc2Icache_req), 32'h0);
        chk({tag, " reset valid"}, 32'(insts_out_valid), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        pend  = 1'b0;
    endtask

    task automatic chk_head(string tag, logic [31:0] pc0);
        chk({tag, " valid"}, 32'(insts_out_valid), 32'h1);
        chk({tag, " pc0"},   insts_out[0].pc, pc0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; acc_addr = '0; pend = 1'b0; pend_cnt = 0;
        lat = 1; auto_ic = 1'b0; Icache2proc_data = '0;
        reset = 1'b1;
        idle_inputs();

        //           st    rd    rpc           pt    ppc           rdy   dv    ordy  req   addr          val   mask   pc0           pc2           npc3
        vecs[0]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h000,      1'b0, 4'h0,  32'h0,        32'h0,        32'h0);
        vecs[1]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0,  32'h0,        32'h0,        32'h0);
        vecs[2]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h010,      1'b1, 4'hF,  32'h000,      32'h008,      32'h010);
        vecs[3]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 4'hF,  32'h000,      32'h008,      32'h010);
        vecs[4]  = v(1'b0, 1'b0, 32'h0,        1'b1, 32'h400,      1'b1, 1'b0, 1'b1, 1'b1, 32'h020,      1'b1, 4'hF,  32'h000,      32'h008,      32'h010);
        vecs[5]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 4'hF,  32'h010,      32'h018,      32'h020);
        vecs[6]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h400,      1'b1, 4'hF,  32'h020,      32'h028,      32'h400);
        vecs[7]  = v(1'b0, 1'b1, 32'h108,      1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'hF,  32'h020,      32'h028,      32'h400);
        vecs[8]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0,  32'h0,        32'h0,        32'h0);
        vecs[9]  = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 4'h0,  32'h0,        32'h0,        32'h0);
        vecs[10] = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0,  32'h0,        32'h0,        32'h0);
        vecs[11] = v(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h110,      1'b1, 4'hC,  32'h100,      32'h108,      32'h110);

        repeat (2) @(negedge clock);
        #1;
        chk("reset req",   32'(proc2Icache_req), 32'h0);
        chk("reset valid", 32'(insts_out_valid), 32'h0);
        chk("reset mask",  32'(insts_out_mask),  32'h0);
        chk("reset bp_pc", bp_pc,                32'h0);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            stall                  = vecs[k].stall;
            redirect               = vecs[k].redirect;
            redirect_pc            = vecs[k].redirect_pc;
            pred_taken             = vecs[k].pred_taken;
            pc_predicted           = vecs[k].pc_predicted;
            Icache2proc_ready      = vecs[k].ready;
            Icache2proc_data_valid = vecs[k].dv;
            Icache2proc_data       = group_data(acc_addr);
            insts_out_ready        = vecs[k].out_ready;
            #1;
            chk($sformatf("row%0d req", k),   32'(proc2Icache_req), 32'(vecs[k].e_req));
            if (vecs[k].e_req)
                chk($sformatf("row%0d addr", k), proc2Icache_addr, vecs[k].e_addr);
            chk($sformatf("row%0d valid", k), 32'(insts_out_valid), 32'(vecs[k].e_valid));
            chk($sformatf("row%0d mask", k),  32'(insts_out_mask),  32'(vecs[k].e_mask));
            if (vecs[k].e_valid) begin
                chk($sformatf("row%0d pc0", k),   insts_out[0].pc,  vecs[k].e_pc0);
                chk($sformatf("row%0d pc2", k),   insts_out[2].pc,  vecs[k].e_pc2);
                chk($sformatf("row%0d npc3", k),  insts_out[3].npc, vecs[k].e_npc3);
                chk($sformatf("row%0d inst3", k), insts_out[3].inst, inst_word(vecs[k].e_pc0, 3));
            end
            ic_sample();
        end

        // Mid-run reset with a group still queued, then fill the queue with no consumer.
        do_reset("fill");
        auto_ic = 1'b1; lat = 1; n_acc = 0;
        for (int c = 0; c < 20; c++) begin
            Icache2proc_ready = 1'b1;
            ic_drive();
            #1;
            if (c == 0) begin
                chk("fill first addr",  proc2Icache_addr, 32'h0);
                chk("fill first valid", 32'(insts_out_valid), 32'h0);
            end
            if (proc2Icache_req && Icache2proc_ready) n_acc++;
            if (c == 19) begin
                chk("fill req held low", 32'(proc2Icache_req), 32'h0);
                chk_head("fill head", 32'h0);
            end
            ic_sample();
            @(negedge clock);
        end
        chk("fill accept count", 32'(n_acc), 32'd4);

        insts_out_ready = 1'b1;
        for (int d = 0; d < 5; d++) begin
            ic_drive();
            #1;
            chk_head($sformatf("drain%0d", d), 32'(d * 16));
            if (d == 0) chk("drain0 req", 32'(proc2Icache_req), 32'h0);
            if (d == 1) begin
                chk("drain1 req",  32'(proc2Icache_req), 32'h1);
                chk("drain1 addr", proc2Icache_addr, 32'h40);
            end
            ic_sample();
            @(negedge clock);
        end

        // Redirect while waiting; the late response must be dropped.
        auto_ic = 1'b0;
        do_reset("kill");
        auto_ic = 1'b1; lat = 3; Icache2proc_ready = 1'b1; insts_out_ready = 1'b1;
        for (int e = 0; e < 13; e++) begin
            redirect    = (e == 1) || (e == 7) || (e == 11);
            redirect_pc = (e == 1) ? 32'h200 : (e == 7) ? 32'h300 : 32'h500;
            if (e == 8)  lat = 1;
            insts_out_ready   = !(e == 9 || e == 10);
            Icache2proc_ready = !(e == 10 || e == 12);
            ic_drive();
            #1;
            case (e)
                0:  chk("kill e0 addr", proc2Icache_addr, 32'h0);
                1:  chk("kill e1 req",  32'(proc2Icache_req), 32'h0);
                2:  chk("kill e2 req",  32'(proc2Icache_req), 32'h0);
                3:  begin
                        chk("kill e3 req",   32'(proc2Icache_req), 32'h0);
                        chk("kill e3 dv",    32'(Icache2proc_data_valid), 32'h1);
                    end
                4:  begin
                        chk("kill e4 req",   32'(proc2Icache_req), 32'h1);
                        chk("kill e4 addr",  proc2Icache_addr, 32'h200);
                        chk("kill e4 valid", 32'(insts_out_valid), 32'h0);
                    end
                8:  begin
                        chk("coresp req",    32'(proc2Icache_req), 32'h1);
                        chk("coresp addr",   proc2Icache_addr, 32'h300);
                        chk("coresp valid",  32'(insts_out_valid), 32'h0);
                    end
                10: chk_head("codeq pre", 32'h300);
                11: chk("codeq req", 32'(proc2Icache_req), 32'h0);
                12: begin
                        chk("codeq valid", 32'(insts_out_valid), 32'h0);
                        chk("codeq bp_pc", bp_pc, 32'h500);
                    end
                default: ;
            endcase
            ic_sample();
            @(negedge clock);
        end
        redirect = 1'b0;

        // Stall held across a pending response.
        lat = 2; Icache2proc_ready = 1'b1; insts_out_ready = 1'b1;
        for (int f = 0; f < 7; f++) begin
            stall = (f >= 1) && (f <= 5);
            ic_drive();
            #1;
            if (f == 0) chk("stall f0 addr", proc2Icache_addr, 32'h500);
            else if (f <= 5) begin
                chk($sformatf("stall f%0d req", f),   32'(proc2Icache_req), 32'h0);
                chk($sformatf("stall f%0d valid", f), 32'(insts_out_valid), 32'h0);
            end else begin
                chk_head("stall release", 32'h500);
                chk("stall release mask", 32'(insts_out_mask), 32'hF);
            end
            ic_sample();
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_queued.md
Name: inst_fetch_queued

Overview:
- Parametrised successor to the single-group fetch stage.
- Issues aligned fetch-group requests to the I-cache with a req/resp handshake and masks slots below an unaligned PC.
- Buffers returned groups in a QUEUE_DEPTH-entry circular fetch queue with a valid/ready handshake to the instruction buffer.
- Redirects flush the queue and drop any stale in-flight response; sits between branch predictor/I-cache and the decode-side instruction buffer.

Parameters:
FETCH_WIDTH, 4, instructions per fetch group (power of two, 1..8)
INST_WIDTH, 32, bits per instruction and per PC
QUEUE_DEPTH, 4, fetch groups buffered (power of two, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clock  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
stall  in  1  global stall: blocks new requests and forces insts_out_valid low
redirect  in  1  branch resolution / mispredict redirect
redirect_pc  in  INST_WIDTH  new fetch PC
bp_pc  out  INST_WIDTH  current fetch PC, shown to the predictor
pred_taken  in  1  predictor: the group at bp_pc redirects
pc_predicted  in  INST_WIDTH  predicted target when pred_taken
proc2Icache_req  out  1  request valid
proc2Icache_addr  out  INST_WIDTH  group-aligned address
Icache2proc_ready  in  1  I-cache accepts request this cycle
Icache2proc_data_valid  in  1  response valid, at least 1 cycle after acceptance
Icache2proc_data  in  FETCH_WIDTH*INST_WIDTH  slot i at bits [(i+1)*INST_WIDTH-1 : i*INST_WIDTH]
insts_out_valid  out  1  queue head valid
insts_out_ready  in  1  instruction buffer accepts head
insts_out  out  FETCH_WIDTH x ib_entry_t  head group {inst, PC, NPC}
insts_out_mask  out  FETCH_WIDTH  per-slot valid bits of head group

Behaviour:
- Reset (synchronous, active-high, clock named clock): fetch_pc=RESET_PC, FSM=FETCH, queue empty (head=tail=count=0). Outputs: req=0, insts_out_valid=0, mask=0.
- Address split: OFF = log2(FETCH_WIDTH*4). aligned = fetch_pc with low OFF bits cleared; proc2Icache_addr = aligned. First valid slot s = fetch_pc[OFF-1:2]. bp_pc = fetch_pc.
- FSM states:
  - FETCH: req = ~stall & ~redirect & (count < QUEUE_DEPTH). On req & ready: latch request PC/slot into in-flight register, then go to WAIT.
  - WAIT: await Icache2proc_data_valid, then enqueue and go to FETCH. No new request while in WAIT (one outstanding at most).
  - KILL: await response, discard it, go to FETCH.
- Next PC is sampled when the request is accepted: fetch_pc <= pred_taken ? pc_predicted : aligned + FETCH_WIDTH*4. Arithmetic is modulo 2^INST_WIDTH; wrap-around is silent.
- Enqueue entry fields:
  - inst[i] = data slot i; PC[i] = aligned + 4i.
  - NPC[i] = PC[i]+4, except the last slot, whose NPC is the sampled next fetch PC.
  - mask bit i = (i >= s).
- Count <= QUEUE_DEPTH guarantee: a request is issued only when count < QUEUE_DEPTH, and only one can be in flight, so a response always finds a free entry.
- Dequeue when insts_out_valid & insts_out_ready. insts_out_valid = (count != 0) & ~stall. Output is the head entry, driven from registers (no combinational path from the I-cache to insts_out).
- Simultaneous enqueue and dequeue: count unchanged. This holds at full and empty, with head/tail wrapping modulo QUEUE_DEPTH.
- Redirect has highest priority. In the same cycle it:
  - clears the queue; any coincident dequeue has no effect, and a same-cycle response is dropped;
  - sets fetch_pc <= redirect_pc;
  - moves FSM WAIT->KILL (or WAIT->FETCH if the response arrives that same cycle), KILL->KILL, FETCH->FETCH with no request issued that cycle.
- Stall: no new request and no dequeue. Responses still enqueue, and redirect still acts.
- Reset mid-operation: state returns to reset values next cycle. A later response belonging to a pre-reset request is ignored, because FSM=FETCH does not accept data_valid.

Decomposition:
- ib_entry_t and INST_WIDTH stay in the shared defines package.
- Add there: FETCH_WIDTH and QUEUE_DEPTH defaults, and a fetch-state enum {FETCH, WAIT, KILL}.
- One sub-module: fetch_group_queue, a parametrised circular FIFO of {ib_entry_t[FETCH_WIDTH], mask} with flush, full, count, and head outputs.

Test Plan:
- Reset, RESET_PC=0, FETCH_WIDTH=4, ready=1, 1-cycle latency -> addr 0x0, then 0x10, 0x20; head PC 0x0/0x4/0x8/0xC, last NPC 0x10, mask 4'b1111.
- Redirect to 0x108 while idle -> next addr 0x100; mask 4'b1100; slot 2 PC 0x108; slot 3 NPC 0x110.
- pred_taken=1, pc_predicted=0x400 on accept at 0x20 -> group 0x20 last NPC 0x400; next addr 0x400.
- insts_out_ready=0 with QUEUE_DEPTH=4 -> exactly 4 groups enqueued, req stays 0. Raise ready -> one dequeue per cycle, and fetch resumes once count<4.
- Redirect to 0x200 in WAIT, response arriving 3 cycles later -> response discarded, queue empty, next request addr 0x200. Also check redirect coinciding with a response and with a dequeue.
- Stall held 5 cycles with a response pending -> response enqueued, insts_out_valid=0 and no req throughout; on release head valid in the same cycle.
